// File: rtl/transaccion_pkg.sv
// Shared types and defaults for the per-channel word counter.
package transaccion_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    PEND = 1'b1
  } estado_t;

  localparam int NUM_CH_DEF = 4;
  localparam int CNT_W_DEF  = 5;

  // Index width for n channels, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/contador_palabras_param_if.sv
// Pop/readout bundle between the transaction layer and the word counter.
interface contador_palabras_param_if
  import transaccion_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int IDX_W  = idx_w(NUM_CH)
) ();

  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] fifo_empty;
  logic              idle;
  logic              clear;
  logic              req;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  data;
  logic              valid;
  logic [IDX_W-1:0]  idx_out;
  logic              idx_err;
  logic [NUM_CH-1:0] overflow;

  modport master (
    output pop, fifo_empty, idle, clear, req, idx,
    input  data, valid, idx_out, idx_err, overflow
  );

  modport slave (
    input  pop, fifo_empty, idle, clear, req, idx,
    output data, valid, idx_out, idx_err, overflow
  );

endinterface

// File: rtl/contador_canal.sv
// One saturating word counter with a sticky overflow flag.
module contador_canal
  import transaccion_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  input  logic             rd_clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Counter state: global clear beats read-clear, read-clear keeps a same-cycle pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= {CNT_W{1'b0}};
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= {CNT_W{1'b0}};
      ovf <= 1'b0;
    end else if (rd_clr) begin
      cnt <= inc ? CNT_W'(1) : {CNT_W{1'b0}};
      ovf <= 1'b0;
    end else if (inc) begin
      if (cnt == CNT_MAX) begin
        ovf <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/contador_palabras_param.sv
// Per-channel popped-word counters with a req/idx readout that waits for idle.
module contador_palabras_param
  import transaccion_pkg::*;
#(
  parameter int NUM_CH        = NUM_CH_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int IDX_W         = idx_w(NUM_CH),
  parameter int CLEAR_ON_READ = 0
) (
  input logic                   clk,
  input logic                   reset,
  contador_palabras_param_if.slave bus
);

  estado_t           state_r, state_s;
  logic [IDX_W-1:0]  pend_idx_r, pend_idx_s, svc_idx_s;
  logic              svc_s, idx_err_s;
  logic [CNT_W-1:0]  rd_data_s;
  logic [CNT_W-1:0]  cnt_s [NUM_CH];
  logic [NUM_CH-1:0] inc_s, rd_clr_s, ovf_s;

  assign inc_s        = bus.pop & ~bus.fifo_empty;
  assign bus.overflow = ovf_s;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_canal
    contador_canal #(.CNT_W(CNT_W)) u_canal (
      .clk    (clk),
      .reset  (reset),
      .inc    (inc_s[g]),
      .clr    (bus.clear),
      .rd_clr (rd_clr_s[g]),
      .cnt    (cnt_s[g]),
      .ovf    (ovf_s[g])
    );
  end

  // Readout FSM register and pending channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= RUN;
      pend_idx_r <= {IDX_W{1'b0}};
    end else begin
      state_r    <= state_s;
      pend_idx_r <= pend_idx_s;
    end
  end

  // Next state and service decision; in PEND the newest request replaces the latched one.
  always_comb begin
    state_s    = state_r;
    pend_idx_s = pend_idx_r;
    svc_s      = 1'b0;
    svc_idx_s  = bus.idx;
    case (state_r)
      RUN: begin
        if (bus.req) begin
          if (bus.idle) begin
            svc_s = 1'b1;
          end else begin
            state_s    = PEND;
            pend_idx_s = bus.idx;
          end
        end else begin
          state_s = RUN;
        end
      end
      PEND: begin
        if (bus.idle) begin
          svc_s     = 1'b1;
          svc_idx_s = pend_idx_r;
          state_s   = bus.req ? PEND : RUN;
        end else begin
          state_s = PEND;
        end
        pend_idx_s = bus.req ? bus.idx : pend_idx_r;
      end
      default: begin
        state_s = RUN;
      end
    endcase
  end

  // Channel mux and read-clear strobes; out-of-range indices select nothing.
  always_comb begin
    rd_data_s = {CNT_W{1'b0}};
    rd_clr_s  = {NUM_CH{1'b0}};
    idx_err_s = (32'(svc_idx_s) >= NUM_CH);
    for (int i = 0; i < NUM_CH; i++) begin
      rd_data_s   = (svc_idx_s == IDX_W'(i)) ? cnt_s[i] : rd_data_s;
      rd_clr_s[i] = svc_s && (CLEAR_ON_READ != 0) && (svc_idx_s == IDX_W'(i));
    end
  end

  // Registered response; data/idx_out/idx_err hold between services.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.valid   <= 1'b0;
      bus.data    <= {CNT_W{1'b0}};
      bus.idx_out <= {IDX_W{1'b0}};
      bus.idx_err <= 1'b0;
    end else begin
      bus.valid <= svc_s;
      if (svc_s) begin
        bus.data    <= idx_err_s ? {CNT_W{1'b0}} : rd_data_s;
        bus.idx_out <= svc_idx_s;
        bus.idx_err <= idx_err_s;
      end
    end
  end

endmodule

// File: tb/tb_contador_palabras_param.sv
// Scoreboard bench: two counters (plain and clear-on-read) share one stimulus path.
module tb_contador_palabras_param;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pop, fe;
  logic       idle, clr, req, sel;
  logic [2:0] idx;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    logic [4:0] data;
    logic [2:0] idx;
    logic       err;
    int         cyc;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  contador_palabras_param_if #(.NUM_CH(4), .CNT_W(5), .IDX_W(3)) ifa ();
  contador_palabras_param_if #(.NUM_CH(4), .CNT_W(5), .IDX_W(2)) ifb ();

  assign ifa.pop        = sel ? 4'b0000 : pop;
  assign ifa.fifo_empty = fe;
  assign ifa.idle       = idle;
  assign ifa.clear      = clr;
  assign ifa.req        = req & ~sel;
  assign ifa.idx        = idx;
  assign ifb.pop        = sel ? pop : 4'b0000;
  assign ifb.fifo_empty = fe;
  assign ifb.idle       = idle;
  assign ifb.clear      = clr;
  assign ifb.req        = req & sel;
  assign ifb.idx        = idx[1:0];

  contador_palabras_param #(.NUM_CH(4), .CNT_W(5), .IDX_W(3), .CLEAR_ON_READ(0)) dut_a (
    .clk(clk), .reset(rst), .bus(ifa));
  contador_palabras_param #(.NUM_CH(4), .CNT_W(5), .IDX_W(2), .CLEAR_ON_READ(1)) dut_b (
    .clk(clk), .reset(rst), .bus(ifb));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic [3:0] p, input logic [3:0] e, input logic i,
                       input logic c, input logic r, input logic [2:0] x);
    @(negedge clk);
    pop = p; fe = e; idle = i; clr = c; req = r; idx = x;
  endtask

  task automatic expect_rd(input logic [4:0] d, input logic [2:0] x, input logic err, input int lat);
    q.push_back('{d, x, err, cyc + lat});
  endtask

  task automatic read(input logic [2:0] x, input logic [4:0] d, input logic err);
    drive(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, x);
    expect_rd(d, x, err, 1);
  endtask

  task automatic nop();
    drive(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 3'd0);
  endtask

  // Monitor: every valid pulse must match the oldest expectation, on its cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (ifa.valid || ifb.valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid=1 expected none (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("rd_cycle", cyc, e.cyc);
        chk("rd_data", ifa.valid ? ifa.data : ifb.data, e.data);
        chk("rd_idx", ifa.valid ? ifa.idx_out : {1'b0, ifb.idx_out}, e.idx);
        chk("rd_err", ifa.valid ? ifa.idx_err : ifb.idx_err, e.err);
      end
    end
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_valid: got none expected data=%0d idx=%0d at cycle %0d", e.data, e.idx, e.cyc);
    end
  end

  initial begin
    rst = 1'b1; pop = 4'b0; fe = 4'b0; idle = 1'b1; clr = 1'b0; req = 1'b0; idx = 3'd0; sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", ifa.valid, 0);
    chk("rst_data", ifa.data, 0);
    chk("rst_idx_out", ifa.idx_out, 0);
    chk("rst_idx_err", ifa.idx_err, 0);
    chk("rst_overflow", ifa.overflow, 0);
    rst = 1'b0;

    // Basic count and read.
    repeat (4) drive(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 3'd0);
    read(3'd0, 5'd4, 1'b0);

    // Saturation, then clear.
    repeat (33) drive(4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 3'd0);
    read(3'd1, 5'd31, 1'b0);
    nop();
    chk("ovf_saturated", ifa.overflow, 4'b0010);
    drive(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 3'd0);
    nop();
    chk("ovf_cleared", ifa.overflow, 4'b0000);
    read(3'd1, 5'd0, 1'b0);
    read(3'd0, 5'd0, 1'b0);

    // Request held in PEND until idle rises three cycles later.
    repeat (3) drive(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 3'd0);
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 3'd2);
    repeat (2) drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0);
    drive(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 3'd0);
    expect_rd(5'd3, 3'd2, 1'b0, 1);
    nop();

    // Read samples the pre-increment value; out-of-range index; streaming.
    drive(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 3'd0);
    repeat (2) drive(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 3'd0);
    drive(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1, 3'd0);
    expect_rd(5'd2, 3'd0, 1'b0, 1);
    read(3'd0, 5'd3, 1'b0);
    read(3'd5, 5'd0, 1'b1);
    read(3'd0, 5'd3, 1'b0);

    // Last request wins while pending.
    repeat (2) drive(4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 3'd0);
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 3'd0);
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 3'd2);
    drive(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 3'd0);
    expect_rd(5'd0, 3'd2, 1'b0, 1);

    // New request in the same cycle the pending one is serviced.
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 3'd0);
    drive(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 3'd1);
    expect_rd(5'd3, 3'd0, 1'b0, 1);
    expect_rd(5'd2, 3'd1, 1'b0, 2);
    nop();
    nop();

    // Asynchronous reset while a request is pending.
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 3'd0);
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_data", ifa.data, 0);
    chk("async_rst_idx_out", ifa.idx_out, 0);
    chk("async_rst_valid", ifa.valid, 0);
    drive(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 3'd0);
    rst = 1'b0;
    repeat (3) nop();
    read(3'd0, 5'd0, 1'b0);
    nop();

    // Clear-on-read instance.
    sel = 1'b1;
    repeat (5) drive(4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0, 3'd0);
    read(3'd3, 5'd5, 1'b0);
    read(3'd3, 5'd0, 1'b0);
    drive(4'b1000, 4'b1000, 1'b1, 1'b0, 1'b1, 3'd3);
    expect_rd(5'd0, 3'd3, 1'b0, 1);
    drive(4'b1000, 4'b0000, 1'b1, 1'b0, 1'b1, 3'd3);
    expect_rd(5'd0, 3'd3, 1'b0, 1);
    read(3'd3, 5'd1, 1'b0);
    repeat (3) nop();
    chk("cor_overflow", ifb.overflow, 0);
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/contador_palabras_param.md
Name: contador_palabras_param

Overview:
Parametrised per-channel word counter for the transaction layer. It counts words popped from each output FIFO and returns a channel's count through a req/idx readout port. This generation generalises the fixed 4-channel, 5-bit counter: channel count and count width are parameters, counters saturate with a sticky overflow flag, clear-on-read is optional, and a request made while the FSM is not idle is held until idle. It sits beside the output FIFOs and is driven by the transaction FSM's idle indication.

Parameters:
NUM_CH, 4, number of output FIFO channels counted (>=1)
CNT_W, 5, width of each counter and of data
IDX_W, $clog2(NUM_CH) (min 1), width of idx/idx_out
CLEAR_ON_READ, 0, 1 = counter of the read channel is zeroed when its value is returned

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  asynchronous, active-high reset
pop  input  NUM_CH  pop strobe to each output FIFO
fifo_empty  input  NUM_CH  empty flag of each output FIFO
idle  input  1  transaction FSM is in IDLE (all FIFOs empty)
clear  input  1  synchronous clear of all counters and overflow flags
req  input  1  readout request
idx  input  IDX_W  channel to read
data  output  CNT_W  returned count (registered)
valid  output  1  data/idx_out valid for one cycle per serviced request
idx_out  output  IDX_W  channel that data belongs to
idx_err  output  1  serviced idx was >= NUM_CH
overflow  output  NUM_CH  sticky saturation flag per channel

Behaviour:
- Reset (async, active-high): all counters 0, overflow 0, data 0, valid 0, idx_out 0, idx_err 0, state RUN, pending cleared.
- Count: at posedge, cnt[i] += 1 when pop[i] && !fifo_empty[i]. A pop on an empty FIFO is ignored.
- Saturation: if cnt[i] == 2^CNT_W-1 and a valid pop arrives, cnt[i] holds and overflow[i] sets. overflow[i] stays set until clear or reset.
- clear: zeroes all counters and overflow in that cycle and has priority over increments. A read serviced in the same cycle returns the pre-clear value. clear does not cancel a pending request.
- Readout FSM, states RUN and PEND:
  - RUN, req=1, idle=1: service. On the next cycle valid=1, data=cnt[idx] as sampled before any same-cycle increment, idx_out=idx.
  - RUN, req=1, idle=0: latch idx, go to PEND, valid=0.
  - PEND, idle=0: wait. A new req overwrites the latched idx (last request wins).
  - PEND, idle=1: service the latched idx (valid the following cycle) and return to RUN. A req arriving in that same cycle is serviced on the next cycle.
- Streaming: req held high with idle=1 gives valid every cycle, and data follows idx with 1-cycle latency.
- Out-of-range idx (>= NUM_CH): valid=1, data=0, idx_err=1, no counter affected.
- Clear-on-read (CLEAR_ON_READ=1): the read counter becomes 0 + (valid pop that cycle ? 1 : 0). The read channel's overflow flag is also cleared.
- valid is a one-cycle pulse per service. data and idx_out hold their last value when valid=0.
- Reset asserted mid-PEND drops the pending request; no response follows.

Decomposition:
- Package transaccion_pkg: state typedef (RUN, PEND) and default constants for NUM_CH and CNT_W.
- Sub-module contador_canal: one saturating counter with inc, clr and rd_clr inputs and cnt and ovf outputs, instantiated NUM_CH times via generate.
- Top level holds the readout FSM and the output mux.

Test Plan:
- Reset, then 4 valid pops on ch0; idle=1, req=1, idx=0 -> next cycle valid=1, data=4, idx_out=0, idx_err=0.
- 33 valid pops on ch1 (CNT_W=5) -> read gives data=31, overflow[1]=1; clear -> read gives data=0, overflow[1]=0.
- idle=0, req pulse idx=2 after 3 valid pops on ch2; idle rises 3 cycles later -> valid=1 exactly one cycle after idle rises, data=3, idx_out=2, and no earlier valid.
- CLEAR_ON_READ=1, ch3 at 5: read -> data=5; read again -> data=0. Pop on empty ch3 plus read -> data=0.
- ch0 at 2; pop on ch0 in the same cycle as a read of ch0 -> data=2; next read -> data=3. A req with idx=5 when NUM_CH=4 (IDX_W=3) -> valid=1, data=0, idx_err=1.
- Request latched in PEND, then reset asserted asynchronously between edges -> outputs zero immediately, and no valid after idle rises.
